// File: rtl/ram8_arbiter.sv
// ram8_arbiter: shares one single-port RAM (async read, clocked write)
// between requester A and requester B using per-requester req/ack handshakes.
// The RAM command is registered; each access owns the RAM for one cycle and
// the owner is acked, with read data captured, on the closing edge.
module ram8_arbiter #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 8,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_wr,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_wr,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic              ram_en,
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);
  localparam int   NUM_REQ = 2;
  localparam logic REQ_A   = 1'b0;
  localparam logic REQ_B   = 1'b1;
  localparam bit   FIXED   = (FIXED_PRIO != 0);

  typedef enum logic {IDLE, ACCESS} state_t;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  cmd_t [NUM_REQ-1:0] cmd;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] done;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_q, last_d;
  logic                ram_en_q, ram_en_d;
  logic                ram_wr_q, ram_wr_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_din_q, ram_din_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic [NUM_REQ-1:0][DATA_W-1:0] rdata_q, rdata_d;

  logic gnt;
  logic sel;

  assign req    = {b_req, a_req};
  assign cmd[0] = cmd_t'{wr: a_wr, addr: a_addr, wdata: a_wdata};
  assign cmd[1] = cmd_t'{wr: b_wr, addr: b_addr, wdata: b_wdata};

  // A requester in flight or being acked this cycle does not compete.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    assign done[i] = (state_q == ACCESS) & (owner_q == 1'(i));
    assign elig[i] = req[i] & ~ack_q[i] & ~done[i];
  end

  // Pick a winner: B on a tie in fixed mode, otherwise whoever did not go last.
  always_comb begin
    gnt = |elig;
    sel = REQ_A;
    if (elig[1] & (~elig[0] | FIXED | (last_q == REQ_A))) sel = REQ_B;
  end

  // Next RAM command and ownership; addr/din hold when no access issues.
  always_comb begin
    state_d    = IDLE;
    owner_d    = owner_q;
    last_d     = last_q;
    ram_en_d   = 1'b0;
    ram_wr_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    if (gnt) begin
      state_d    = ACCESS;
      owner_d    = sel;
      last_d     = sel;
      ram_en_d   = 1'b1;
      ram_wr_d   = cmd[sel].wr;
      ram_addr_d = cmd[sel].addr;
      ram_din_d  = cmd[sel].wdata;
    end
  end

  // Completion: pulse the owner's ack and latch read data for reads only.
  always_comb begin
    ack_d   = '0;
    rdata_d = rdata_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (done[i]) begin
        ack_d[i] = 1'b1;
        if (!ram_wr_q) rdata_d[i] = ram_dout;
      end
    end
  end

  // All state registers; reset wins even over a completing access.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= REQ_A;
      last_q     <= REQ_B;
      ram_en_q   <= 1'b0;
      ram_wr_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      ack_q      <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      ram_en_q   <= ram_en_d;
      ram_wr_q   <= ram_wr_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
    end
  end

  assign a_ack    = ack_q[0];
  assign b_ack    = ack_q[1];
  assign a_rdata  = rdata_q[0];
  assign b_rdata  = rdata_q[1];
  assign ram_en   = ram_en_q;
  assign ram_wr   = ram_wr_q;
  assign ram_addr = ram_addr_q;
  assign ram_din  = ram_din_q;

endmodule

// File: tb/tb_ram8_arbiter.sv
// Bench for ram8_arbiter: a round-robin instance with a RAM model and a
// scoreboard (transactions queued at issue, checked at ack against a shadow
// memory updated in ack order), plus a fixed-priority instance for tie cases.
module tb_ram8_arbiter;
  localparam int AW = 15;
  localparam int DW = 8;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] d;
    int            t;
  } txn_t;

  logic clk = 0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  // round-robin DUT
  logic          reset;
  logic          a_req, a_wr, b_req, b_wr;
  logic [AW-1:0] a_addr, b_addr, ram_addr;
  logic [DW-1:0] a_wdata, b_wdata, a_rdata, b_rdata, ram_din, ram_dout;
  logic          a_ack, b_ack, ram_en, ram_wr;

  // fixed-priority DUT
  logic          f_reset;
  logic          f_a_req, f_a_wr, f_b_req, f_b_wr;
  logic [AW-1:0] f_a_addr, f_b_addr, f_ram_addr;
  logic [DW-1:0] f_a_wdata, f_b_wdata, f_a_rdata, f_b_rdata, f_ram_din, f_ram_dout;
  logic          f_a_ack, f_b_ack, f_ram_en, f_ram_wr;

  logic [DW-1:0] mem0   [0:(1<<AW)-1];
  logic [DW-1:0] mem1   [0:(1<<AW)-1];
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  logic [DW-1:0] hold   [2];
  txn_t qa[$], qb[$];
  bit mon_en = 0;

  ram8_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(0)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .ram_en(ram_en), .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout));

  ram8_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1)) dut_f (
    .clk(clk), .reset(f_reset),
    .a_req(f_a_req), .a_wr(f_a_wr), .a_addr(f_a_addr), .a_wdata(f_a_wdata),
    .a_ack(f_a_ack), .a_rdata(f_a_rdata),
    .b_req(f_b_req), .b_wr(f_b_wr), .b_addr(f_b_addr), .b_wdata(f_b_wdata),
    .b_ack(f_b_ack), .b_rdata(f_b_rdata),
    .ram_en(f_ram_en), .ram_wr(f_ram_wr), .ram_addr(f_ram_addr), .ram_din(f_ram_din),
    .ram_dout(f_ram_dout));

  // RAM models: async read, write on clock edge when en & wr
  always @(posedge clk) if (ram_en && ram_wr) mem0[ram_addr] <= ram_din;
  always @(posedge clk) if (f_ram_en && f_ram_wr) mem1[f_ram_addr] <= f_ram_din;
  assign ram_dout   = mem0[ram_addr];
  assign f_ram_dout = mem1[f_ram_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard for one requester: ack order equals RAM commit order
  task automatic score(input int p, input logic ack, input logic [DW-1:0] rd);
    txn_t  t;
    string nm;
    int    lat;
    nm = (p == 0) ? "a" : "b";
    if (!ack) begin
      chk({nm, "_rdata_hold"}, rd, hold[p]);
    end else if ((p == 0) ? (qa.size() == 0) : (qb.size() == 0)) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_spurious_ack: got ack=1, expected no ack (cycle %0d)", nm, cyc);
    end else begin
      t = (p == 0) ? qa.pop_front() : qb.pop_front();
      if (!t.wr) begin
        chk({nm, "_read_data"}, rd, shadow[t.addr]);
        hold[p] = shadow[t.addr];
      end else begin
        chk({nm, "_write_rdata_hold"}, rd, hold[p]);
        shadow[t.addr] = t.d;
      end
      lat = cyc - t.t;
      n_chk++;
      if (lat < 2 || lat > 4) begin
        n_fail++;
        $display("FAIL %s_latency: got %0d cycles, expected 2..4", nm, lat);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("ack_exclusive", {31'd0, a_ack & b_ack}, 32'd0);
      score(0, a_ack, a_rdata);
      score(1, b_ack, b_rdata);
    end
  end

  task automatic set_a(input logic wr, input logic [AW-1:0] ad, input logic [DW-1:0] d, input bit push);
    a_req = 1; a_wr = wr; a_addr = ad; a_wdata = d;
    if (push) qa.push_back('{wr: wr, addr: ad, d: d, t: cyc});
  endtask

  task automatic set_b(input logic wr, input logic [AW-1:0] ad, input logic [DW-1:0] d, input bit push);
    b_req = 1; b_wr = wr; b_addr = ad; b_wdata = d;
    if (push) qb.push_back('{wr: wr, addr: ad, d: d, t: cyc});
  endtask

  task automatic a_txn(input logic wr, input logic [AW-1:0] ad, input logic [DW-1:0] d, output int lat);
    set_a(wr, ad, d, 1);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (a_ack) begin lat = i; break; end
    end
    a_req = 0;
    if (lat < 0) chk("a_ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic b_txn(input logic wr, input logic [AW-1:0] ad, input logic [DW-1:0] d, output int lat);
    set_b(wr, ad, d, 1);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (b_ack) begin lat = i; break; end
    end
    b_req = 0;
    if (lat < 0) chk("b_ack_timeout", 32'd0, 32'd1);
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom);
    return AW'($urandom_range(0, 7));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, cnt;
    for (int i = 0; i < (1 << AW); i++) begin
      mem0[i] = '0; mem1[i] = '0; shadow[i] = '0;
    end
    hold[0] = '0; hold[1] = '0;
    reset = 1; f_reset = 1;
    a_req = 0; a_wr = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_wr = 0; b_addr = '0; b_wdata = '0;
    f_a_req = 0; f_a_wr = 0; f_a_addr = '0; f_a_wdata = '0;
    f_b_req = 0; f_b_wr = 0; f_b_addr = '0; f_b_wdata = '0;
    repeat (3) tick();
    reset = 0;
    tick();
    chk("rst_a_ack", {31'd0, a_ack}, 0);
    chk("rst_b_ack", {31'd0, b_ack}, 0);
    chk("rst_a_rdata", {24'd0, a_rdata}, 0);
    chk("rst_b_rdata", {24'd0, b_rdata}, 0);
    chk("rst_ram_en", {31'd0, ram_en}, 0);
    chk("rst_ram_wr", {31'd0, ram_wr}, 0);
    chk("rst_ram_addr", {17'd0, ram_addr}, 0);
    chk("rst_ram_din", {24'd0, ram_din}, 0);
    mon_en = 1;

    // single read
    mem0[15'h1234] = 8'h5A; shadow[15'h1234] = 8'h5A;
    set_a(0, 15'h1234, 8'h00, 1);
    tick();
    chk("rd_ram_en", {31'd0, ram_en}, 1);
    chk("rd_ram_addr", {17'd0, ram_addr}, 32'h1234);
    chk("rd_ack_early", {31'd0, a_ack}, 0);
    tick();
    chk("rd_a_ack", {31'd0, a_ack}, 1);
    chk("rd_a_rdata", {24'd0, a_rdata}, 32'h5A);
    chk("rd_b_ack", {31'd0, b_ack}, 0);
    a_req = 0;
    repeat (2) tick();

    // B write then read of the top address
    b_txn(1, 15'h7FFF, 8'hC3, lat);
    chk("b_wr_latency", lat, 2);
    tick();
    b_txn(0, 15'h7FFF, 8'h00, lat);
    chk("b_rd_latency", lat, 2);
    chk("b_rd_data", {24'd0, b_rdata}, 32'hC3);
    chk("a_rdata_unchanged", {24'd0, a_rdata}, 32'h5A);
    tick();

    // round-robin tie: A first, B back-to-back
    set_a(0, 15'h0010, 8'h00, 1);
    set_b(0, 15'h0020, 8'h00, 1);
    tick();
    chk("rr_c1_en", {31'd0, ram_en}, 1);
    chk("rr_c1_addr", {17'd0, ram_addr}, 32'h0010);
    tick();
    chk("rr_c2_a_ack", {31'd0, a_ack}, 1);
    chk("rr_c2_en", {31'd0, ram_en}, 1);
    chk("rr_c2_addr", {17'd0, ram_addr}, 32'h0020);
    a_req = 0;
    tick();
    chk("rr_c3_b_ack", {31'd0, b_ack}, 1);
    chk("rr_c3_a_ack", {31'd0, a_ack}, 0);
    b_req = 0;
    tick();

    // withdraw: A loses a tie, then drops req
    a_txn(0, 15'h0005, 8'h00, lat);
    tick();
    set_b(0, 15'h0030, 8'h00, 1);
    set_a(1, 15'h0200, 8'hEE, 0);
    tick();
    chk("wd_b_granted", {17'd0, ram_addr}, 32'h0030);
    a_req = 0;
    tick();
    chk("wd_b_ack", {31'd0, b_ack}, 1);
    b_req = 0;
    cnt = 0;
    repeat (5) begin tick(); if (a_ack) cnt++; end
    chk("wd_no_a_ack", cnt, 0);
    chk("wd_no_write", {24'd0, mem0[15'h0200]}, 0);

    // reset during an ACCESS write
    set_a(1, 15'h0100, 8'h11, 0);
    tick();
    chk("rm_ram_en", {31'd0, ram_en}, 1);
    chk("rm_ram_wr", {31'd0, ram_wr}, 1);
    mon_en = 0;
    reset = 1;
    a_req = 0;
    tick();
    chk("rm_mem_written", {24'd0, mem0[15'h0100]}, 32'h11);
    chk("rm_a_ack", {31'd0, a_ack}, 0);
    chk("rm_ram_en0", {31'd0, ram_en}, 0);
    chk("rm_ram_wr0", {31'd0, ram_wr}, 0);
    chk("rm_ram_addr0", {17'd0, ram_addr}, 0);
    chk("rm_ram_din0", {24'd0, ram_din}, 0);
    chk("rm_a_rdata0", {24'd0, a_rdata}, 0);
    chk("rm_b_rdata0", {24'd0, b_rdata}, 0);
    reset = 0;
    shadow[15'h0100] = 8'h11;
    hold[0] = '0; hold[1] = '0;
    mon_en = 1;
    tick();

    // random contention, scoreboard-checked
    fork
      begin
        int l;
        repeat (150) begin
          repeat ($urandom_range(0, 2)) tick();
          a_txn(1'($urandom_range(0, 1)), rnd_addr(), 8'($urandom), l);
        end
      end
      begin
        int l;
        repeat (150) begin
          repeat ($urandom_range(0, 2)) tick();
          b_txn(1'($urandom_range(0, 1)), rnd_addr(), 8'($urandom), l);
        end
      end
    join
    repeat (4) tick();
    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);

    // fixed priority: B wins the tie even right after reset
    mem1[15'h0011] = 8'h66; mem1[15'h0022] = 8'h77;
    f_reset = 0;
    tick();
    f_a_req = 1; f_a_addr = 15'h0011;
    f_b_req = 1; f_b_addr = 15'h0022;
    tick();
    chk("fp_b_first", {17'd0, f_ram_addr}, 32'h0022);
    tick();
    chk("fp_b_ack", {31'd0, f_b_ack}, 1);
    chk("fp_b_rdata", {24'd0, f_b_rdata}, 32'h77);
    chk("fp_a_granted", {17'd0, f_ram_addr}, 32'h0011);
    tick();
    chk("fp_a_ack", {31'd0, f_a_ack}, 1);
    chk("fp_a_rdata", {24'd0, f_a_rdata}, 32'h66);
    f_a_req = 0; f_b_req = 0;
    repeat (3) tick();
    // single requester holding req: one access per three cycles
    f_b_req = 1;
    cnt = 0;
    repeat (30) begin tick(); if (f_b_ack) cnt++; end
    chk("fp_b_rate", cnt, 10);
    f_b_req = 0;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
